// File: rtl/ebtb_pkg.sv
// Shared symbol codes and link-state encoding for the 8b/10b transmit link controller.
package ebtb_pkg;

    localparam logic [7:0] K_IDLE  = 8'hBC;  // K.28.5 idle / comma / fill
    localparam logic [7:0] K_SOF   = 8'hFB;  // K.27.7
    localparam logic [7:0] K_EOF   = 8'hFD;  // K.29.7
    localparam logic [7:0] K_ABORT = 8'hFE;  // K.30.7

    typedef enum logic [2:0] {
        StDisabled,
        StSync,
        StIdle,
        StData,
        StEof,
        StAbort
    } link_state_e;

endpackage

// File: rtl/tx_link_ctrl.sv
// Transmit link framer: emits one registered symbol per clock toward an external 8b/10b
// encoder, wrapping requester bytes in SOF/EOF with idle gaps and periodic comma insertion.
module tx_link_ctrl
    import ebtb_pkg::*;
#(
    parameter int unsigned SYNC_CNT     = 4,
    parameter int unsigned IDLE_GAP     = 2,
    parameter int unsigned ALIGN_PERIOD = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        s_ready,
    output logic        enc_k,
    output logic [7:0]  enc_eb,
    input  logic        enc_k_err,
    output logic        err,
    output logic [15:0] frm_cnt
);

    localparam int unsigned SW = (SYNC_CNT > 1) ? $clog2(SYNC_CNT) : 1;
    localparam int unsigned GW = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
    localparam int unsigned AW = (ALIGN_PERIOD > 0) ? $clog2(ALIGN_PERIOD + 1) : 1;

    localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_CNT - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(IDLE_GAP);
    localparam logic [AW-1:0] ALIGN_MAX = AW'(ALIGN_PERIOD);

    link_state_e r_state;
    logic          r_enc_k;
    logic [7:0]    r_enc_eb;
    logic          r_err;
    logic [15:0]   r_frm_cnt;
    logic [SW-1:0] r_sync;
    logic [GW-1:0] r_gap;
    logic [AW-1:0] r_align;

    logic w_align_due;
    logic w_gap_met;

    assign w_align_due = (r_align == ALIGN_MAX);
    assign w_gap_met   = (r_gap >= GAP_MAX);

    // en low wins over a pending byte, so readiness is withdrawn combinationally.
    assign s_ready = !reset && en && (r_state == StData) && !w_align_due;

    assign enc_k   = r_enc_k;
    assign enc_eb  = r_enc_eb;
    assign err     = r_err;
    assign frm_cnt = r_frm_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StDisabled;
            r_enc_k   <= 1'b1;
            r_enc_eb  <= K_IDLE;
            r_err     <= 1'b0;
            r_frm_cnt <= '0;
            r_sync    <= '0;
            r_gap     <= '0;
            r_align   <= '0;
        end else begin
            r_err    <= r_err | enc_k_err;
            r_enc_k  <= 1'b1;
            r_enc_eb <= K_IDLE;

            unique case (r_state)
                StDisabled: begin
                    r_gap <= '0;
                    if (en) begin
                        r_state <= StSync;
                        r_sync  <= '0;
                    end
                end

                StSync: begin
                    if (!en) begin
                        r_state <= StDisabled;
                    end else if (r_sync == SYNC_LAST) begin
                        r_state <= StIdle;
                    end else begin
                        r_sync <= r_sync + 1'b1;
                    end
                end

                StIdle: begin
                    if (!en) begin
                        r_state <= StDisabled;
                    end else if (s_valid && w_gap_met) begin
                        r_enc_eb <= K_SOF;
                        r_state  <= StData;
                        r_align  <= '0;
                    end else if (!w_gap_met) begin
                        r_gap <= r_gap + 1'b1;
                    end
                end

                StData: begin
                    if (!en) begin
                        r_enc_eb <= K_ABORT;
                        r_state  <= StAbort;
                    end else if (s_valid && !w_align_due) begin
                        r_enc_k  <= 1'b0;
                        r_enc_eb <= s_data;
                        r_align  <= r_align + 1'b1;
                        if (s_last) begin
                            r_state <= StEof;
                        end
                    end else begin
                        // Fill symbol doubles as the forced comma, restarting the run.
                        r_align <= '0;
                    end
                end

                StEof: begin
                    r_enc_eb  <= K_EOF;
                    r_frm_cnt <= r_frm_cnt + 16'd1;
                    r_gap     <= '0;
                    r_state   <= StIdle;
                end

                StAbort: begin
                    r_state <= StDisabled;
                end

                default: begin
                    r_state <= StDisabled;
                end
            endcase
        end
    end

endmodule
